grant_path_mux: RTL and testbench

- Sits directly downstream of the two-requester arbiter.
- Consumes grant_1/grant_2 and routes the granted requester's payload into a single-entry output holding register, which drives the shared resource via a valid/ready handshake.
- Acknowledges each captured transfer back to its requester.
- Also acts as a security monitor on the grant path: flags conflicting grants, grants issued without a request, and requester starvation.

---
 rtl/grant_path_mux_pkg.sv | 21 ++
 rtl/grant_path_mux_starve_counter.sv | 47 ++++
 rtl/grant_path_mux.sv | 151 +++++++++++++++
 tb/tb_grant_path_mux.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/grant_path_mux_pkg.sv
// Shared types and default constants for the grant-path mux slice.
// Holds the source and holding-register state enums plus default widths.
package grant_path_mux_pkg;

    // Which requester the held payload came from.
    typedef enum logic {
        SRC_1 = 1'b0,
        SRC_2 = 1'b1
    } src_t;

    // Single-entry output holding register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_STARVE_MAX = 15;
    localparam int DEF_CNT_W      = 4;

endpackage

// File: rtl/grant_path_mux_starve_counter.sv
// Per-requester starvation counter with a registered alarm output.
// Ports: clk, reset (async, active-low), pending (request outstanding),
//        served (request acknowledged this cycle), alarm (counter at max).
module starve_counter
    import grant_path_mux_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic pending,
    input  logic served,
    output logic alarm
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             alarm_q;

    // Count consecutive cycles of waiting; any gap or service restarts.
    always_comb begin
        cnt_d = cnt_q;
        if (!pending || served) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Alarm is a flop loaded from the next count, so it tracks
    // the counter value exactly but never glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            alarm_q <= (cnt_d == MAX_CNT);
        end
    end

    assign alarm = alarm_q;

endmodule

// File: rtl/grant_path_mux.sv
// Routes the granted requester's payload into a one-entry holding
// register driving a shared resource (valid/ready), acks captures, and
// monitors the grant path for conflicts, spurious grants and starvation.
// Ports:
//   clk, reset (async, active-low)
//   req_1/req_2, grant_1/grant_2, data_1/data_2 : requester side
//   ack_1/ack_2 : combinational capture acknowledge
//   out_valid/out_data/out_src/out_ready : resource handshake
//   conflict_err/spurious_err : sticky flags, err_clear clears
//   starve_1/starve_2 : starvation alarms
module grant_path_mux
    import grant_path_mux_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_1,
    input  logic              req_2,
    input  logic              grant_1,
    input  logic              grant_2,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    output logic              ack_1,
    output logic              ack_2,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic              conflict_err,
    output logic              spurious_err,
    output logic              starve_1,
    output logic              starve_2,
    input  logic              err_clear
);

    hold_state_t       state_q;
    hold_state_t       state_d;
    logic [DATA_W-1:0] data_q;
    src_t              src_q;
    logic              conflict_q;
    logic              spurious_q;

    logic conflict;
    logic spurious;
    logic elig_1;
    logic elig_2;
    logic can_load;
    logic load;

    // Grant-path decode. Simultaneous grants are never arbitrated here.
    assign conflict = grant_1 && grant_2;
    assign spurious = (grant_1 && !req_1) || (grant_2 && !req_2);
    assign elig_1   = grant_1 && req_1 && !conflict;
    assign elig_2   = grant_2 && req_2 && !conflict;

    // While reset is asserted the register refuses loads, keeping acks
    // low even though reset does not wait for a clock edge.
    assign can_load = reset && ((state_q == EMPTY) || out_ready);
    assign load     = ack_1 || ack_2;

    // Holding-register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load wins over a drain, giving pass-through refill.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    // FSM outputs.
    always_comb begin
        ack_1     = 1'b0;
        ack_2     = 1'b0;
        out_valid = (state_q == FULL);
        if (can_load) begin
            ack_1 = elig_1;
            ack_2 = elig_2;
        end
    end

    // Payload capture; the eligibility terms are mutually exclusive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            src_q  <= SRC_1;
        end else if (load) begin
            data_q <= ack_2 ? data_2 : data_1;
            src_q  <= ack_2 ? SRC_2 : SRC_1;
        end
    end

    // Sticky flags: a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            if (conflict) begin
                conflict_q <= 1'b1;
            end else if (err_clear) begin
                conflict_q <= 1'b0;
            end
            if (spurious) begin
                spurious_q <= 1'b1;
            end else if (err_clear) begin
                spurious_q <= 1'b0;
            end
        end
    end

    starve_counter #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_1 (
        .clk     (clk),
        .reset   (reset),
        .pending (req_1),
        .served  (ack_1),
        .alarm   (starve_1)
    );

    starve_counter #(
        .CNT_W      (CNT_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_2 (
        .clk     (clk),
        .reset   (reset),
        .pending (req_2),
        .served  (ack_2),
        .alarm   (starve_2)
    );

    assign out_data     = data_q;
    assign out_src      = src_q;
    assign conflict_err = conflict_q;
    assign spurious_err = spurious_q;

endmodule

// File: tb/tb_grant_path_mux.sv
// Scoreboard bench for grant_path_mux: a transaction-level model predicts
// acks, flags and alarms; a monitor pops expected payloads on handshakes.
module tb_grant_path_mux;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_1 = 1'b0, req_2 = 1'b0;
    logic       grant_1 = 1'b0, grant_2 = 1'b0;
    logic [7:0] data_1 = '0, data_2 = '0;
    logic       ack_1, ack_2;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_src;
    logic       out_ready = 1'b0;
    logic       conflict_err, spurious_err;
    logic       starve_1, starve_2;
    logic       err_clear = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model state: occupancy, sticky flags, consecutive-wait counts.
    logic       m_full = 1'b0;
    logic       m_conf = 1'b0;
    logic       m_spur = 1'b0;
    int         m_wait1 = 0;
    int         m_wait2 = 0;
    logic [8:0] sb[$];

    grant_path_mux dut (
        .clk          (clk),
        .reset        (reset),
        .req_1        (req_1),
        .req_2        (req_2),
        .grant_1      (grant_1),
        .grant_2      (grant_2),
        .data_1       (data_1),
        .data_2       (data_2),
        .ack_1        (ack_1),
        .ack_2        (ack_2),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_ready    (out_ready),
        .conflict_err (conflict_err),
        .spurious_err (spurious_err),
        .starve_1     (starve_1),
        .starve_2     (starve_2),
        .err_clear    (err_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance it.
    task automatic step(input logic r1, input logic r2, input logic g1,
                        input logic g2, input logic [7:0] d1,
                        input logic [7:0] d2, input logic rdy,
                        input logic clr);
        logic e1, e2, accept;
        @(negedge clk);
        req_1 = r1; req_2 = r2; grant_1 = g1; grant_2 = g2;
        data_1 = d1; data_2 = d2; out_ready = rdy; err_clear = clr;
        #1;
        accept = !m_full || rdy;
        e1 = accept && g1 && r1 && !g2;
        e2 = accept && g2 && r2 && !g1;
        check("ack_1", ack_1, e1);
        check("ack_2", ack_2, e2);
        check("out_valid", out_valid, m_full);
        check("conflict_err", conflict_err, m_conf);
        check("spurious_err", spurious_err, m_spur);
        check("starve_1", starve_1, m_wait1 == 15);
        check("starve_2", starve_2, m_wait2 == 15);
        if (e1) sb.push_back({1'b0, d1});
        if (e2) sb.push_back({1'b1, d2});
        if (e1 || e2) m_full = 1'b1;
        else if (m_full && rdy) m_full = 1'b0;
        if (g1 && g2) m_conf = 1'b1;
        else if (clr) m_conf = 1'b0;
        if ((g1 && !r1) || (g2 && !r2)) m_spur = 1'b1;
        else if (clr) m_spur = 1'b0;
        m_wait1 = (!r1 || e1) ? 0 : (m_wait1 < 15 ? m_wait1 + 1 : 15);
        m_wait2 = (!r2 || e2) ? 0 : (m_wait2 < 15 ? m_wait2 + 1 : 15);
    endtask

    task automatic idle(input logic rdy, input logic clr);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rdy, clr);
    endtask

    // Monitor: every accepted output must match the oldest expected one.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e[7:0]);
                    check("out_src", out_src, e[8]);
                end
            end
        end
    end

    initial begin
        int pat;
        logic r1, r2, g1, g2;
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_src", out_src, 1'b0);
        check("rst_conf", conflict_err, 1'b0);
        check("rst_spur", spurious_err, 1'b0);
        check("rst_starve", {starve_1, starve_2}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Single transfer.
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // Backpressure, then pass-through refill.
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h22, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // Conflict, clear, and clear colliding with a new conflict.
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 1'b1, 1'b1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);

        // Spurious grant.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h55, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);

        // Starvation on requester 1, then service.
        for (int i = 0; i < 17; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h66, 8'h00, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        // Async reset while full, flagged and starving.
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 8'h02, 1'b0, 1'b0);
        check("pre_rst_starve2", starve_2, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_conf", conflict_err, 1'b0);
        check("arst_starve", {starve_1, starve_2}, 2'b00);
        check("arst_ack", {ack_1, ack_2}, 2'b00);
        check("arst_data", out_data, 8'h00);
        sb.delete();
        m_full = 1'b0; m_conf = 1'b0; m_spur = 1'b0;
        m_wait1 = 0; m_wait2 = 0;
        @(negedge clk);
        req_1 = 1'b0; req_2 = 1'b0; grant_1 = 1'b0; grant_2 = 1'b0;
        reset = 1'b1;
        idle(1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r1 = ($urandom_range(0, 3) != 0);
            r2 = ($urandom_range(0, 3) != 0);
            pat = $urandom_range(0, 19);
            g1 = (pat < 8) || (pat == 19);
            g2 = (pat >= 8 && pat < 16) || (pat == 19);
            step(r1, r2, g1, g2, 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
        end
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
